// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned multiplier: add-and-shift over the multiplier bits,
// finishing early as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        s,
    input  logic        LA,
    input  logic        EB,
    input  logic [7:0]  DataA,
    input  logic [7:0]  DataB,
    output logic [15:0] P,
    output logic        Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] a_reg;
    logic [7:0]  b_reg;
    logic [15:0] p_reg;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= IDLE;
            a_reg     <= 16'h0000;
            b_reg     <= 8'h00;
            p_reg     <= 16'h0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Operand loads taken on the start edge feed the new run.
                    if (LA) a_reg <= {8'h00, DataA};
                    if (EB) b_reg <= DataB;
                    if (s) begin
                        p_reg     <= 16'h0000;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (b_reg == 8'h00) begin
                        state_reg <= DONE;
                    end else begin
                        if (b_reg[0]) p_reg <= p_reg + a_reg;
                        a_reg <= {a_reg[14:0], 1'b0};
                        b_reg <= {1'b0, b_reg[7:1]};
                    end
                end
                DONE: begin
                    // Holding s high keeps the result; only s low re-arms a start.
                    if (!s) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign P    = p_reg;
    assign Done = (state_reg == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: hand-computed products and latencies,
// start/hold behaviour, ignored loads during a run and asynchronous reset abort.
module tb_shift_add_multiplier;

    logic        Clock;
    logic        Resetn;
    logic        s;
    logic        LA;
    logic        EB;
    logic [7:0]  DataA;
    logic [7:0]  DataB;
    logic [15:0] P;
    logic        Done;

    int errors = 0;
    int checks = 0;

    shift_add_multiplier dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .s      (s),
        .LA     (LA),
        .EB     (EB),
        .DataA  (DataA),
        .DataB  (DataB),
        .P      (P),
        .Done   (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Load both operands in IDLE with a one-cycle LA/EB pulse; ends on a negedge.
    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        DataA = a;
        DataB = b;
        LA    = 1'b1;
        EB    = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        LA    = 1'b0;
        EB    = 1'b0;
    endtask

    // Start from IDLE (called on a negedge), count edges from the sampling edge
    // inclusive until Done, then check hold while s=1 and return to IDLE on s=0.
    task automatic do_run(input string tag, input int exp_edges, input logic [15:0] exp_p,
                          input bit inject_load);
        int  edges;
        bit  done_seen;
        edges     = 0;
        done_seen = 1'b0;
        s         = 1'b1;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(posedge Clock);
            edges++;
            @(negedge Clock);
            if (inject_load) begin
                if (edges == 1) begin
                    LA    = 1'b1;
                    EB    = 1'b1;
                    DataA = 8'hAA;
                    DataB = 8'hFF;
                end else begin
                    LA = 1'b0;
                    EB = 1'b0;
                end
            end
            if (Done) done_seen = 1'b1;
        end
        LA = 1'b0;
        EB = 1'b0;
        check({tag, "_latency"}, edges, exp_edges);
        check({tag, "_p"}, {16'h0, P}, {16'h0, exp_p});
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check({tag, "_hold_done"}, {31'h0, Done}, 32'd1);
        check({tag, "_hold_p"}, {16'h0, P}, {16'h0, exp_p});
        s = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check({tag, "_idle_done"}, {31'h0, Done}, 32'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check({tag, "_idle_p"}, {16'h0, P}, {16'h0, exp_p});
        check({tag, "_idle_stays"}, {31'h0, Done}, 32'd0);
    endtask

    initial begin
        Resetn = 1'b0;
        s      = 1'b0;
        LA     = 1'b0;
        EB     = 1'b0;
        DataA  = 8'h00;
        DataB  = 8'h00;
        #12;
        check("reset_p", {16'h0, P}, 32'h0);
        check("reset_done", {31'h0, Done}, 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        // 7*2, k=2
        load_ops(8'h07, 8'h02);
        do_run("mul_07_02", 4, 16'h000E, 1'b0);

        // 255*255, k=8
        load_ops(8'hFF, 8'hFF);
        do_run("mul_ff_ff", 10, 16'hFE01, 1'b0);

        // zero multiplier finishes right away
        load_ops(8'h35, 8'h00);
        do_run("mul_35_00", 2, 16'h0000, 1'b0);

        // loads pulsed during RUN are ignored
        load_ops(8'h0C, 8'h0A);
        do_run("mul_0c_0a_la", 6, 16'h0078, 1'b1);

        // restart without loading: B was shifted down to zero
        do_run("restart_noload", 2, 16'h0000, 1'b0);

        // operands loaded in the start cycle itself are used
        DataA = 8'h05;
        DataB = 8'h03;
        LA    = 1'b1;
        EB    = 1'b1;
        do_run("load_on_start", 4, 16'h000F, 1'b0);

        // async reset mid-run with a partially accumulated product
        load_ops(8'hFF, 8'hFF);
        s = 1'b1;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("partial_nonzero", {31'h0, (P != 16'h0)}, 32'd1);
        #2 Resetn = 1'b0;
        #1;
        check("abort_p", {16'h0, P}, 32'h0);
        check("abort_done", {31'h0, Done}, 32'd0);
        s = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        // after reset B is zero, so an unloaded start completes in 2 edges
        do_run("post_reset_noload", 2, 16'h0000, 1'b0);

        // 9*0x80 aborted by reset mid-run, then reloaded and rerun
        load_ops(8'h09, 8'h80);
        s = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        check("abort2_p", {16'h0, P}, 32'h0);
        check("abort2_done", {31'h0, Done}, 32'd0);
        s = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        load_ops(8'h09, 8'h80);
        do_run("mul_09_80", 10, 16'h0480, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
